tm1637_ctrl: RTL and testbench
==============================

Name: tm1637_ctrl

Overview:
- Parametrised TM1637 LED-display controller. Successor to the fixed demo driver.
- Takes a digit vector, brightness and on/off control through a start/busy/done handshake.
- Emits the full three-frame TM1637 write transaction on an open-drain two-wire bus: data command, address plus digit data, display control.
- Adds ACK checking, a sticky error flag and an encoded debug step output. Sits between display-content logic and the board's tm1637 pins.

Parameters:
- NUM_DIGITS, 4, digits sent per transaction; legal range 1..6.
- CLK_DIV, 250, clk_50M cycles per bus half-period (CLK_DIV >= 2). The default gives 100 kHz.

Ports:
- clk_50M  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  transaction request; accepted only when busy=0.
- digits  in  8*NUM_DIGITS  segment bytes; digits[7:0] is digit 0, sent first.
- brightness  in  3  display brightness level, 0..7.
- display_on  in  1  1 = display enabled.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle pulse at the end of a transaction.
- ack_err  out  1  sticky flag: a missing ACK occurred in the last transaction.
- tm1637_clk  out  1  bus clock, push-pull.
- tm1637_dio_oe  out  1  1 = pull DIO low; 0 = release DIO (external pull-up).
- tm1637_dio_in  in  1  sampled DIO level.
- tm1637_vcc  out  1  display power enable.
- debug_step_id  out  7  {state[2:0], bit_idx[3:0]}.

Behaviour:
- Reset values (next edge with rst_n=0): busy=0, done=0, ack_err=0, tm1637_clk=1, tm1637_dio_oe=0, tm1637_vcc=0, debug_step_id=0. Divider and FSM go to IDLE.
- tm1637_vcc is 1 on every cycle after reset is released.
- Reset mid-transaction aborts immediately to the reset values. No stop condition is generated.
- Start acceptance: start=1 at an edge where busy=0 latches digits, brightness and display_on, clears ack_err, sets busy, and zeroes the divider.
  - Start is accepted in the same cycle that done=1 (busy is already 0).
  - Start while busy=1 is ignored. Latched data is unaffected by input changes during the transaction.
- Timing: each half-period lasts exactly CLK_DIV cycles. Bus outputs change only on half-period boundaries.
- Logical bit 1 means tm1637_dio_oe=0; logical 0 means tm1637_dio_oe=1.
- FSM states and codes: IDLE=0, START=1, BIT=2, ACK=3, STOP=4.
  - START: two half-periods with CLK=1. DIO is released in the first and pulled low in the second.
  - BIT: per bit, half-period A sets CLK=0 and DIO=data bit; half-period B sets CLK=1. Bits go LSB first; bit_idx = 0..7.
  - ACK: half-period A sets CLK=0 and DIO released; half-period B sets CLK=1. tm1637_dio_in is sampled on the last cycle of B; a sampled 1 sets ack_err. The transaction continues regardless.
  - STOP: three half-periods: (CLK=0, DIO=0), (CLK=1, DIO=0), (CLK=1, DIO released).
- Frames:
  - Frame 1: START, byte 0x40, ACK, STOP.
  - Frame 2: START, 0xC0, ACK, then digit 0..NUM_DIGITS-1, each followed by ACK, then STOP.
  - Frame 3: START, (0x80 | display_on<<3 | brightness), ACK, STOP.
  - Frames run back-to-back with no idle gap.
- Latency: total of 69+18*NUM_DIGITS half-periods. done=1 and busy=0 on the cycle exactly (69+18*NUM_DIGITS)*CLK_DIV cycles after busy first reads 1.
- Bus at transaction end is CLK=1, DIO released.
- Idle outputs: CLK=1, DIO released, debug_step_id=0.
- debug_step_id bit_idx is 0 outside BIT.
- ack_err holds its value until the next accepted start or reset.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> busy=0, done=0, ack_err=0, tm1637_clk=1, tm1637_dio_oe=0, debug_step_id=0; tm1637_vcc=1 after release.
- Normal write (NUM_DIGITS=4, CLK_DIV=4), digits=0x3F065B4F, brightness=7, display_on=1, bus model ACKs -> decoded bytes 0x40 | 0xC0,0x4F,0x5B,0x06,0x3F | 0x8F; three start/stop pairs; done pulses 564 cycles after busy rises; ack_err=0.
- No ACK (tm1637_dio_in held 1) -> same byte sequence and 564-cycle length; ack_err=1 from the first ACK sample; stays 1 after done; cleared on the next accepted start.
- start pulsed during busy with different digits -> ignored; the bus carries the original bytes. start held high through done -> new transaction accepted in the done cycle, busy stays high.
- rst_n=0 for one cycle at half-period 50 -> next cycle tm1637_clk=1, tm1637_dio_oe=0, busy=0, no done. A following start completes in 564 cycles.
- display_on=0, brightness=2 -> control byte 0x82. Repeat with NUM_DIGITS=1 -> 87 half-periods (348 cycles).

Source files
------------

// File: rtl/tm1637_ctrl.sv
// tm1637_ctrl: TM1637 LED display write controller.
// A start/busy/done handshake triggers one complete write. The write is three
// back-to-back frames on the two-wire bus: data command 0x40; address 0xC0
// followed by NUM_DIGITS segment bytes; display control. Every byte is sent
// LSB first. A missing ACK sets the sticky ack_err flag, and the write still
// runs to the end.
// Ports:
//   clk_50M, rst_n      clock; synchronous active-low reset
//   start               request a write; taken only when busy=0
//   digits              segment bytes, digits[7:0] goes first
//   brightness          display brightness 0..7
//   display_on          1 = display enabled
//   busy, done          write in progress / one-cycle end-of-write pulse
//   ack_err             sticky missing-ACK flag for the last write
//   tm1637_clk          bus clock (push-pull)
//   tm1637_dio_oe       1 = pull DIO low, 0 = release DIO
//   tm1637_dio_in       sampled DIO level
//   tm1637_vcc          display power enable
//   debug_step_id       {state, bit index}
module tm1637_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 250
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] digits,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic                    tm1637_clk,
    output logic                    tm1637_dio_oe,
    input  logic                    tm1637_dio_in,
    output logic                    tm1637_vcc,
    output logic [6:0]              debug_step_id
);

    localparam int             DW        = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [2:0]     LAST_BYTE = 3'(NUM_DIGITS);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BIT   = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t                       state, state_nxt;
    logic [1:0]                   hp, hp_nxt;          // half-period within the state
    logic [2:0]                   bit_idx, bit_idx_nxt;
    logic [1:0]                   frame, frame_nxt;
    logic [2:0]                   byte_cnt, byte_cnt_nxt; // frame 2: 0 = address, k = digit k-1
    logic [DW-1:0]                div, div_nxt;
    logic [NUM_DIGITS-1:0][7:0]   digits_q, digits_nxt;
    logic [2:0]                   bri_q, bri_nxt;
    logic                         on_q, on_nxt;
    logic                         busy_nxt, done_nxt, ack_err_nxt, scl_nxt, oe_nxt;
    logic                         tick;
    logic [7:0]                   cur_byte, nxt_digit;

    assign tick = (div == DIV_LAST);

    // Byte on the wire now, and the digit that follows the current ACK in frame 2.
    always_comb begin
        nxt_digit = 8'h00;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (byte_cnt == 3'(i)) nxt_digit = digits_q[i];
        case (frame)
            2'd0: cur_byte = 8'h40;
            2'd1: begin
                cur_byte = 8'hC0;
                for (int i = 0; i < NUM_DIGITS; i++)
                    if (byte_cnt == 3'(i + 1)) cur_byte = digits_q[i];
            end
            default: cur_byte = {4'h8, on_q, bri_q};
        endcase
    end

    // Outputs are registered and only move when a half-period ends, so each
    // branch sets the bus levels for the next half-period.
    always_comb begin
        state_nxt    = state;
        hp_nxt       = hp;
        bit_idx_nxt  = bit_idx;
        frame_nxt    = frame;
        byte_cnt_nxt = byte_cnt;
        div_nxt      = div;
        digits_nxt   = digits_q;
        bri_nxt      = bri_q;
        on_nxt       = on_q;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        ack_err_nxt  = ack_err;
        scl_nxt      = tm1637_clk;
        oe_nxt       = tm1637_dio_oe;

        if (state == IDLE) begin
            if (start) begin
                state_nxt    = START;
                hp_nxt       = 2'd0;
                bit_idx_nxt  = 3'd0;
                frame_nxt    = 2'd0;
                byte_cnt_nxt = 3'd0;
                div_nxt      = '0;
                digits_nxt   = digits;
                bri_nxt      = brightness;
                on_nxt       = display_on;
                ack_err_nxt  = 1'b0;
                busy_nxt     = 1'b1;
                scl_nxt      = 1'b1;
                oe_nxt       = 1'b0;
            end
        end else if (!tick) begin
            div_nxt = div + 1'b1;
        end else begin
            div_nxt = '0;
            case (state)
                START: begin
                    if (hp == 2'd0) begin
                        hp_nxt = 2'd1;
                        oe_nxt = 1'b1;            // DIO falls while CLK high
                    end else begin
                        state_nxt   = BIT;
                        hp_nxt      = 2'd0;
                        bit_idx_nxt = 3'd0;
                        scl_nxt     = 1'b0;
                        oe_nxt      = ~cur_byte[0];
                    end
                end
                BIT: begin
                    if (hp == 2'd0) begin
                        hp_nxt  = 2'd1;
                        scl_nxt = 1'b1;
                    end else if (bit_idx == 3'd7) begin
                        state_nxt   = ACK;
                        hp_nxt      = 2'd0;
                        bit_idx_nxt = 3'd0;
                        scl_nxt     = 1'b0;
                        oe_nxt      = 1'b0;
                    end else begin
                        hp_nxt      = 2'd0;
                        bit_idx_nxt = bit_idx + 3'd1;
                        scl_nxt     = 1'b0;
                        oe_nxt      = ~cur_byte[bit_idx + 3'd1];
                    end
                end
                ACK: begin
                    if (hp == 2'd0) begin
                        hp_nxt  = 2'd1;
                        scl_nxt = 1'b1;
                    end else begin
                        if (tm1637_dio_in) ack_err_nxt = 1'b1;
                        hp_nxt  = 2'd0;
                        scl_nxt = 1'b0;
                        if (frame == 2'd1 && byte_cnt < LAST_BYTE) begin
                            state_nxt    = BIT;
                            byte_cnt_nxt = byte_cnt + 3'd1;
                            bit_idx_nxt  = 3'd0;
                            oe_nxt       = ~nxt_digit[0];
                        end else begin
                            state_nxt = STOP;
                            oe_nxt    = 1'b1;
                        end
                    end
                end
                STOP: begin
                    case (hp)
                        2'd0: begin
                            hp_nxt  = 2'd1;
                            scl_nxt = 1'b1;
                        end
                        2'd1: begin
                            hp_nxt = 2'd2;
                            oe_nxt = 1'b0;        // DIO rises while CLK high
                        end
                        default: begin
                            hp_nxt       = 2'd0;
                            byte_cnt_nxt = 3'd0;
                            if (frame == 2'd2) begin
                                state_nxt = IDLE;
                                frame_nxt = 2'd0;
                                busy_nxt  = 1'b0;
                                done_nxt  = 1'b1;
                            end else begin
                                state_nxt = START;
                                frame_nxt = frame + 2'd1;
                            end
                        end
                    endcase
                end
                default: begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    scl_nxt   = 1'b1;
                    oe_nxt    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            state         <= IDLE;
            hp            <= 2'd0;
            bit_idx       <= 3'd0;
            frame         <= 2'd0;
            byte_cnt      <= 3'd0;
            div           <= '0;
            digits_q      <= '0;
            bri_q         <= 3'd0;
            on_q          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            ack_err       <= 1'b0;
            tm1637_clk    <= 1'b1;
            tm1637_dio_oe <= 1'b0;
            tm1637_vcc    <= 1'b0;
        end else begin
            state         <= state_nxt;
            hp            <= hp_nxt;
            bit_idx       <= bit_idx_nxt;
            frame         <= frame_nxt;
            byte_cnt      <= byte_cnt_nxt;
            div           <= div_nxt;
            digits_q      <= digits_nxt;
            bri_q         <= bri_nxt;
            on_q          <= on_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            ack_err       <= ack_err_nxt;
            tm1637_clk    <= scl_nxt;
            tm1637_dio_oe <= oe_nxt;
            tm1637_vcc    <= 1'b1;
        end
    end

    assign debug_step_id = {state, (state == BIT) ? {1'b0, bit_idx} : 4'd0};

endmodule

// File: tb/tb_tm1637_ctrl.sv
// tb_tm1637_ctrl: testbench for tm1637_ctrl.
// It drives two instances: 4 digits and 1 digit, both with CLK_DIV=4.
// A bus monitor decodes START and STOP conditions and the data bytes (LSB
// first). It also acts as a slave that ACKs each byte. The stimulus pushes the
// expected bytes into a queue, and the bench compares them with the decoded
// bytes once done pulses. Every compare goes through an immediate assertion.
module tb_tm1637_ctrl;

    logic        clk_50M = 1'b0;
    logic        rst_n, start0, start1, nack, sel;
    logic [31:0] digits0;
    logic [7:0]  digits1;
    logic [2:0]  bri;
    logic        on;

    logic        busy0, done0, ack0, scl0, oe0, vcc0, din0;
    logic        busy1, done1, ack1, scl1, oe1, vcc1, din1;
    logic [6:0]  dbg0, dbg1;

    always #5 clk_50M = ~clk_50M;

    tm1637_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .start(start0), .digits(digits0),
        .brightness(bri), .display_on(on), .busy(busy0), .done(done0),
        .ack_err(ack0), .tm1637_clk(scl0), .tm1637_dio_oe(oe0),
        .tm1637_dio_in(din0), .tm1637_vcc(vcc0), .debug_step_id(dbg0));

    tm1637_ctrl #(.NUM_DIGITS(1), .CLK_DIV(4)) dut1 (
        .clk_50M(clk_50M), .rst_n(rst_n), .start(start1), .digits(digits1),
        .brightness(bri), .display_on(on), .busy(busy1), .done(done1),
        .ack_err(ack1), .tm1637_clk(scl1), .tm1637_dio_oe(oe1),
        .tm1637_dio_in(din1), .tm1637_vcc(vcc1), .debug_step_id(dbg1));

    // Open-drain line: the master or the slave model can pull it low.
    logic pull = 1'b0;
    logic line0, line1, mon_scl, mon_sda;
    assign line0 = ~(oe0 | (~sel & pull));
    assign line1 = ~(oe1 | (sel & pull));
    assign din0  = nack | line0;
    assign din1  = nack | line1;
    assign mon_scl = sel ? scl1 : scl0;
    assign mon_sda = sel ? line1 : line0;

    logic       busy_s, done_s, ack_s, scl_s, oe_s, vcc_s;
    logic [6:0] dbg_s;
    assign busy_s = sel ? busy1 : busy0;
    assign done_s = sel ? done1 : done0;
    assign ack_s  = sel ? ack1  : ack0;
    assign scl_s  = sel ? scl1  : scl0;
    assign oe_s   = sel ? oe1   : oe0;
    assign vcc_s  = sel ? vcc1  : vcc0;
    assign dbg_s  = sel ? dbg1  : dbg0;

    // Bus monitor. It only appends decoded bytes and counts conditions; the
    // stimulus side reads these through rd_idx and snapshots.
    logic [7:0] got_q[$];
    int         starts = 0, stops = 0, clr_req = 0, clr_seen = 0, bitcnt = 0;
    logic       in_frame = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] shreg = 8'h00;

    always @(negedge clk_50M) begin
        if (clr_req != clr_seen) begin
            clr_seen = clr_req;
            in_frame = 1'b0;
            bitcnt   = 0;
            pull     = 1'b0;
        end else if (prev_scl && mon_scl && prev_sda && !mon_sda) begin
            starts++;
            in_frame = 1'b1;
            bitcnt   = 0;
        end else if (prev_scl && mon_scl && !prev_sda && mon_sda) begin
            stops++;
            in_frame = 1'b0;
            bitcnt   = 0;
        end else if (!prev_scl && mon_scl && in_frame) begin
            if (bitcnt < 8) begin
                shreg[bitcnt] = mon_sda;
                bitcnt++;
                if (bitcnt == 8) got_q.push_back(shreg);
            end else begin
                bitcnt = 0;                   // ACK clock
            end
        end else if (prev_scl && !mon_scl) begin
            pull = (bitcnt == 8);             // slave drives ACK after 8 bits
        end
        prev_scl = mon_scl;
        prev_sda = mon_sda;
    end

    int         total = 0, passes = 0, rd_idx = 0, len, s_st, s_sp;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passes++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_txn(input logic [47:0] d, input int n, input logic [2:0] b, input logic o);
        exp_q.push_back(8'h40);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < n; i++) exp_q.push_back(d[8*i +: 8]);
        exp_q.push_back({4'h8, o, b});
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        check({tag, "_nbytes"}, got_q.size() - rd_idx, exp_q.size());
        while (exp_q.size() > 0 && rd_idx < got_q.size()) begin
            check($sformatf("%s_byte%0d", tag, k), got_q[rd_idx], exp_q.pop_front());
            rd_idx++;
            k++;
        end
        exp_q.delete();
        rd_idx = got_q.size();
    endtask

    // Called at a negedge; returns at the first cycle busy reads 1 (offset 0).
    task automatic go();
        s_st = starts;
        s_sp = stops;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk_50M);
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_rise", busy_s, 1'b1);
    endtask

    task automatic wait_done(input int elapsed, output int n);
        n = elapsed;
        while (done_s !== 1'b1 && n < 5000) begin
            @(negedge clk_50M);
            n++;
        end
    endtask

    task automatic finish_txn(input string tag, input int explen);
        check({tag, "_latency"}, len, explen);
        check({tag, "_busy_at_done"}, busy_s, 1'b0);
        drain(tag);
        check({tag, "_starts"}, starts - s_st, 3);
        check({tag, "_stops"}, stops - s_sp, 3);
        check({tag, "_bus_clk"}, scl_s, 1'b1);
        check({tag, "_bus_dio"}, oe_s, 1'b0);
    endtask

    initial begin
        sel = 1'b0; nack = 1'b0; rst_n = 1'b0;
        start0 = 1'($urandom); start1 = 1'($urandom);
        digits0 = $urandom; digits1 = 8'($urandom);
        bri = 3'($urandom); on = 1'($urandom);

        // Reset
        repeat (2) @(negedge clk_50M);
        check("rst_busy", busy_s, 1'b0);
        check("rst_done", done_s, 1'b0);
        check("rst_ack", ack_s, 1'b0);
        check("rst_clk", scl_s, 1'b1);
        check("rst_oe", oe_s, 1'b0);
        check("rst_dbg", dbg_s, 7'd0);
        check("rst_vcc", vcc_s, 1'b0);
        start0 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
        @(negedge clk_50M);
        check("vcc_on", vcc_s, 1'b1);
        check("vcc1_on", vcc1, 1'b1);
        check("idle_busy", busy_s, 1'b0);
        clr_req++;
        repeat (2) @(negedge clk_50M);
        rd_idx = got_q.size();

        // Normal write
        digits0 = 32'h3F065B4F; bri = 3'd7; on = 1'b1;
        push_txn({16'h0, digits0}, 4, bri, on);
        go();
        wait_done(0, len);
        finish_txn("norm", 564);
        check("norm_ack", ack_s, 1'b0);

        // No ACK
        repeat (3) @(negedge clk_50M);
        nack = 1'b1;
        push_txn({16'h0, digits0}, 4, bri, on);
        go();
        repeat (79) @(negedge clk_50M);
        check("nack_before", ack_s, 1'b0);
        @(negedge clk_50M);
        check("nack_first", ack_s, 1'b1);
        wait_done(80, len);
        finish_txn("nack", 564);
        check("nack_done", ack_s, 1'b1);
        repeat (5) @(negedge clk_50M);
        check("nack_sticky", ack_s, 1'b1);
        nack = 1'b0;

        // Start during busy is ignored; start held through done is accepted
        push_txn({16'h0, digits0}, 4, bri, on);
        go();
        check("ack_clear", ack_s, 1'b0);
        repeat (100) @(negedge clk_50M);
        digits0 = 32'h11223344;
        start0 = 1'b1;
        @(negedge clk_50M);
        start0 = 1'b0;
        repeat (459) @(negedge clk_50M);
        start0 = 1'b1;
        wait_done(560, len);
        finish_txn("ign", 564);
        push_txn({16'h0, digits0}, 4, bri, on);
        s_st = starts; s_sp = stops;
        @(negedge clk_50M);
        start0 = 1'b0;
        check("b2b_busy", busy_s, 1'b1);
        check("b2b_done", done_s, 1'b0);
        wait_done(0, len);
        finish_txn("b2b", 564);

        // Reset mid-transaction at half-period 50
        repeat (3) @(negedge clk_50M);
        go();
        repeat (200) @(negedge clk_50M);
        rst_n = 1'b0;
        @(negedge clk_50M);
        rst_n = 1'b1;
        clr_req++;
        check("abort_clk", scl_s, 1'b1);
        check("abort_oe", oe_s, 1'b0);
        check("abort_busy", busy_s, 1'b0);
        check("abort_done", done_s, 1'b0);
        @(negedge clk_50M);
        check("abort_nodone", done_s, 1'b0);
        repeat (3) @(negedge clk_50M);
        rd_idx = got_q.size();
        exp_q.delete();
        push_txn({16'h0, digits0}, 4, bri, on);
        go();
        wait_done(0, len);
        finish_txn("post_rst", 564);

        // Display off, brightness 2, with debug step probes
        repeat (3) @(negedge clk_50M);
        digits0 = 32'h7F6D664F; bri = 3'd2; on = 1'b0;
        push_txn({16'h0, digits0}, 4, bri, on);
        go();
        repeat (4) @(negedge clk_50M);
        check("dbg_start", dbg_s, 7'h10);
        repeat (16) @(negedge clk_50M);
        check("dbg_bit1", dbg_s, 7'h21);
        repeat (52) @(negedge clk_50M);
        check("dbg_ack", dbg_s, 7'h30);
        repeat (8) @(negedge clk_50M);
        check("dbg_stop", dbg_s, 7'h40);
        wait_done(80, len);
        finish_txn("ctrl82", 564);
        check("idle_dbg", dbg_s, 7'd0);

        // Single-digit instance
        repeat (3) @(negedge clk_50M);
        sel = 1'b1;
        digits1 = 8'h6D;
        repeat (2) @(negedge clk_50M);
        push_txn({40'h0, digits1}, 1, bri, on);
        go();
        wait_done(0, len);
        finish_txn("one", 348);
        check("one_ack", ack_s, 1'b0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
